// File: rtl/slice_flag_gen.sv
// slice_flag_gen: multi-cycle a - b compare engine producing {v,c,n,z} branch flags,
// one SLICE-bit slice per cycle with the carry chained through a register.
module slice_flag_gen #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic              zacc_q, zacc_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [3:0]        flags_q, flags_d;

    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic [SLICE:0]    slice_sum;
    logic              last_slice;

    // Select the current operand slice and add it with the chained carry
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                a_sl = a_q[i*SLICE +: SLICE];
                b_sl = b_q[i*SLICE +: SLICE];
            end
        end
        slice_sum  = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE{1'b0}}, carry_q};
        last_slice = (k_q == KW'(N - 1));
    end

    // Next-state and datapath update; flush overrides the handshakes
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b1;
                    zacc_d  = 1'b1;
                    k_d     = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (k_q == KW'(i)) begin
                        result_d[i*SLICE +: SLICE] = slice_sum[SLICE-1:0];
                    end
                end
                carry_d = slice_sum[SLICE];
                zacc_d  = zacc_q & (slice_sum[SLICE-1:0] == '0);
                if (last_slice) begin
                    // {v, c, n, z}; the slice MSB is the result sign here
                    flags_d[3] = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                                 (slice_sum[SLICE-1] ^ a_q[WIDTH-1]);
                    flags_d[2] = slice_sum[SLICE];
                    flags_d[1] = slice_sum[SLICE-1];
                    flags_d[0] = zacc_q & (slice_sum[SLICE-1:0] == '0);
                    state_d    = ST_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = ST_IDLE;
            k_d      = '0;
            result_d = result_q;
            flags_d  = flags_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_slice_flag_gen.sv
// Directed self-checking bench for slice_flag_gen (SLICE=8 and SLICE=32 instances).
module tb_slice_flag_gen;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_valid1;
    logic        in_ready;
    logic        in_ready1;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_valid1;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] result1;
    logic [3:0]  flags;
    logic [3:0]  flags1;

    int checks = 0;
    int errors = 0;

    slice_flag_gen #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    slice_flag_gen #(.WIDTH(32), .SLICE(32)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .flags(flags1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands for one edge on the SLICE=8 instance
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges from acceptance (inclusive) until out_valid, bounded
    task automatic wait_ov(input bit sel, output int cyc);
        cyc = 1;
        while (((sel ? out_valid1 : out_valid) !== 1'b1) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 00000000", result); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags); end
        checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_dut1 got rdy=%b vld=%b exp 1/0", in_ready1, out_valid1); end
    endtask

    task automatic test_arith();
        logic [31:0] va [4] = '{32'd5, 32'h8000_0000, 32'd1, 32'h0100_0000};
        logic [31:0] vb [4] = '{32'd5, 32'd1, 32'd2, 32'd0};
        logic [31:0] vr [4] = '{32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0100_0000};
        logic [3:0]  vf [4] = '{4'b0101, 4'b1100, 4'b0010, 4'b0100};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arith%0d_in_ready got %b exp 1", i, in_ready); end
            issue(va[i], vb[i]);
            wait_ov(1'b0, cyc);
            checks++; if (cyc != 5) begin errors++; $display("FAIL arith%0d_latency got %0d exp 5", i, cyc); end
            checks++; if (result !== vr[i]) begin errors++; $display("FAIL arith%0d_result got %h exp %h", i, result, vr[i]); end
            checks++; if (flags !== vf[i]) begin errors++; $display("FAIL arith%0d_flags got %b exp %b", i, flags, vf[i]); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL arith%0d_release got vld=%b rdy=%b exp 0/1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_single_slice();
        int cyc;
        a = 32'h0100_0000;
        b = 32'h0;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        wait_ov(1'b1, cyc);
        checks++; if (cyc != 2) begin errors++; $display("FAIL single_latency got %0d exp 2", cyc); end
        checks++; if (result1 !== 32'h0100_0000) begin errors++; $display("FAIL single_result got %h exp 01000000", result1); end
        checks++; if (flags1 !== 4'b0100) begin errors++; $display("FAIL single_flags got %b exp 0100", flags1); end
        @(posedge clk); #1;
        checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin errors++; $display("FAIL single_release got vld=%b rdy=%b exp 0/1", out_valid1, in_ready1); end
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        issue(32'd10, 32'd3);
        wait_ov(1'b0, cyc);
        checks++; if (cyc != 5) begin errors++; $display("FAIL bp_latency got %0d exp 5", cyc); end
        for (int i = 0; i < 3; i++) begin
            a = 32'hDEAD_BEEF;
            b = 32'd1;
            in_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got vld=%b rdy=%b exp 1/0", i, out_valid, in_ready); end
            checks++; if (result !== 32'd7 || flags !== 4'b0100) begin errors++; $display("FAIL bp_stable%0d got %h/%b exp 00000007/0100", i, result, flags); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got vld=%b rdy=%b exp 0/1", out_valid, in_ready); end
        issue(32'd20, 32'd20);
        wait_ov(1'b0, cyc);
        checks++; if (result !== 32'h0 || flags !== 4'b0101) begin errors++; $display("FAIL bp_next got %h/%b exp 00000000/0101", result, flags); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        a = 32'h7FFF_FFFF;
        b = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Next operands held valid during BUSY/DONE must not disturb the first op
        a = 32'h0000_0100;
        b = 32'h0000_0001;
        wait_ov(1'b0, cyc);
        checks++; if (cyc != 5) begin errors++; $display("FAIL b2b_latency got %0d exp 5", cyc); end
        checks++; if (result !== 32'h8000_0000 || flags !== 4'b1010) begin errors++; $display("FAIL b2b_first got %h/%b exp 80000000/1010", result, flags); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got rdy=%b exp 0", in_ready); end
        wait_ov(1'b0, cyc);
        checks++; if (result !== 32'h0000_00FF || flags !== 4'b0100) begin errors++; $display("FAIL b2b_second got %h/%b exp 000000ff/0100", result, flags); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int cyc;
        bit seen;
        issue(32'h1234_5678, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
        checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL flush_flags_kept got %b exp 0100", flags); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL flush_no_valid got 1 exp 0"); end
        issue(32'd3, 32'd7);
        wait_ov(1'b0, cyc);
        checks++; if (cyc != 5) begin errors++; $display("FAIL flush_next_latency got %0d exp 5", cyc); end
        checks++; if (result !== 32'hFFFF_FFFC || flags !== 4'b0010) begin errors++; $display("FAIL flush_next got %h/%b exp fffffffc/0010", result, flags); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        issue(32'h1234_5678, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
        checks++; if (result !== 32'h0 || flags !== 4'b0000) begin errors++; $display("FAIL rstmid_data got %h/%b exp 00000000/0000", result, flags); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rstmid_no_valid got 1 exp 0"); end
        issue(32'd3, 32'd7);
        wait_ov(1'b0, cyc);
        checks++; if (result !== 32'hFFFF_FFFC || flags !== 4'b0010) begin errors++; $display("FAIL rstmid_next got %h/%b exp fffffffc/0010", result, flags); end
        @(posedge clk); #1;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        a         = '0;
        b         = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_arith();
        test_single_slice();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
